// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding,
// load-use stall, branch flush, data-memory freeze/timeout, perf counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1/2, id_use_rs1/2    ID source registers and their use flags
//   ex_rs1/2, ex_rd           EX source/destination registers
//   ex_mem_read               EX instruction is a load
//   ex_branch_taken           branch resolved taken in EX
//   mem_rd, mem_reg_write     MEM destination and write flag
//   wb_rd, wb_reg_write       WB destination and write flag
//   dmem_req, dmem_ready      data-memory handshake from MEM
//   fwd_a, fwd_b              ALU operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
//   pc_sel, pc_write          PC mux select / PC enable
//   ifid_write, ifid_flush    IF/ID enable / NOP load
//   idex_flush                ID/EX bubble load
//   pipe_hold                 freeze ID/EX, EX/MEM, MEM/WB
//   fault                     sticky memory-timeout fault
//   stall_cycles              saturating count of cycles with pc_write=0
//   flush_events              saturating count of accepted taken branches
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_MEM_WAIT,
        S_FAULT
    } state_t;

    localparam logic [16:0] TIMEOUT   = 17'(MEM_TIMEOUT);
    localparam logic [2:0]  FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_nxt;
    logic [16:0]      w_wait_inc;
    logic [2:0]       r_flush_cnt;
    logic [2:0]       w_flush_nxt;
    logic             r_fault;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flushes;
    logic             w_mem_wait;
    logic             w_load_use;
    logic             w_br_acc;
    logic             w_a_mem;
    logic             w_a_wb;
    logic             w_b_mem;
    logic             w_b_wb;

    // Forwarding: MEM result is newer than WB, so it wins; x0 never forwards.
    assign w_a_mem = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1);
    assign w_a_wb  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs1);
    assign w_b_mem = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2);
    assign w_b_wb  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs2);

    assign fwd_a = rst     ? 2'b00 :
                   w_a_mem ? 2'b10 :
                   w_a_wb  ? 2'b01 : 2'b00;
    assign fwd_b = rst     ? 2'b00 :
                   w_b_mem ? 2'b10 :
                   w_b_wb  ? 2'b01 : 2'b00;

    assign w_mem_wait = dmem_req && !dmem_ready;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        (((ex_rd == id_rs1) && id_use_rs1) ||
                         ((ex_rd == id_rs2) && id_use_rs2));

    // First wait cycle counts as 1, each further one adds 1.
    assign w_wait_inc = (r_state == S_MEM_WAIT) ?
                        ({1'b0, r_wait_cnt} + 17'd1) : 17'd1;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_hold   = 1'b0;
        pc_sel      = 1'b0;
        w_br_acc    = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_flush_nxt = r_flush_cnt;

        if (r_state == S_FAULT) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (w_mem_wait) begin
            // Freeze everything; pending flush count is discarded.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_hold   = 1'b1;
            w_wait_nxt  = w_wait_inc[15:0];
            w_flush_nxt = 3'd0;
            w_state_nxt = (w_wait_inc >= TIMEOUT) ? S_FAULT : S_MEM_WAIT;
        end else if (ex_branch_taken) begin
            // Squashes ID, so any load-use hazard there is moot.
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_br_acc    = 1'b1;
            w_wait_nxt  = 16'd0;
            w_flush_nxt = FL_RELOAD;
            w_state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        end else if (r_state == S_FLUSH) begin
            ifid_flush  = 1'b1;
            w_flush_nxt = r_flush_cnt - 3'd1;
            w_state_nxt = (r_flush_cnt <= 3'd1) ? S_RUN : S_FLUSH;
        end else begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = 16'd0;
            if (w_load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
            pc_sel     = 1'b0;
            w_br_acc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 16'd0;
            r_flush_cnt <= 3'd0;
            r_fault     <= 1'b0;
            r_stall     <= '0;
            r_flushes   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_fault     <= r_fault | (w_state_nxt == S_FAULT);
            if (!pc_write && (r_stall != '1)) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (w_br_acc && (r_flushes != '1)) begin
                r_flushes <= r_flushes + CNT_W'(1);
            end
        end
    end

    assign fault        = r_fault;
    assign stall_cycles = r_stall;
    assign flush_events = r_flushes;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle reference model
// plus directed vectors with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int FC  = 3;
    localparam int MT  = 8;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
    logic [1:0]    fwd_a, fwd_b;
    logic          pc_sel, pc_write, ifid_write, ifid_flush, idex_flush;
    logic          pipe_hold, fault;
    logic [CW-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .pc_sel         (pc_sel),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .pipe_hold      (pipe_hold),
        .fault          (fault),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_flush_left = 0, n_flush_left = 0;
    int m_wait_cnt   = 0, n_wait_cnt   = 0;
    int m_stall      = 0, n_stall      = 0;
    int m_flushes    = 0, n_flushes    = 0;
    bit m_waiting    = 0, n_waiting    = 0;
    bit m_fault      = 0, n_fault      = 0;

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (mem_reg_write && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit e_pcw, e_ifw, e_iff, e_idf, e_hold, e_psel, lu, mw;
        logic [1:0] e_fa, e_fb;
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; e_psel = 0;
        e_fa  = fwd_exp(ex_rs1);
        e_fb  = fwd_exp(ex_rs2);
        n_flush_left = m_flush_left; n_wait_cnt = m_wait_cnt;
        n_stall = m_stall; n_flushes = m_flushes;
        n_waiting = m_waiting; n_fault = m_fault;
        lu = ex_mem_read && ex_rd != 0 &&
             ((ex_rd == id_rs1 && id_use_rs1) ||
              (ex_rd == id_rs2 && id_use_rs2));
        mw = dmem_req && !dmem_ready;
        if (rst) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_fa = 0; e_fb = 0;
            n_flush_left = 0; n_wait_cnt = 0; n_stall = 0; n_flushes = 0;
            n_waiting = 0; n_fault = 0;
        end else if (m_fault) begin
            e_pcw = 0; e_ifw = 0; e_hold = 1;
        end else if (mw) begin
            e_pcw = 0; e_ifw = 0; e_hold = 1;
            n_wait_cnt   = m_waiting ? m_wait_cnt + 1 : 1;
            n_waiting    = 1;
            n_flush_left = 0;
            if (n_wait_cnt >= MT) n_fault = 1;
        end else begin
            n_waiting = 0; n_wait_cnt = 0;
            if (ex_branch_taken) begin
                e_psel = 1; e_iff = 1; e_idf = 1;
                n_flushes    = (m_flushes < SAT) ? m_flushes + 1 : SAT;
                n_flush_left = FC - 1;
            end else if (m_flush_left > 0) begin
                e_iff = 1;
                n_flush_left = m_flush_left - 1;
            end else if (lu) begin
                e_pcw = 0; e_ifw = 0; e_idf = 1;
            end
        end
        if (!rst && !e_pcw) n_stall = (m_stall < SAT) ? m_stall + 1 : SAT;

        chk("m_fwd_a", fwd_a, e_fa);
        chk("m_fwd_b", fwd_b, e_fb);
        chk("m_ctrl", {pc_sel, pc_write, ifid_write, ifid_flush,
                       idex_flush, pipe_hold},
            {e_psel, e_pcw, e_ifw, e_iff, e_idf, e_hold});
        chk("m_fault", fault, m_fault);
        chk("m_stall_cycles", stall_cycles, m_stall);
        chk("m_flush_events", flush_events, m_flushes);
    end

    always @(posedge clk) begin
        m_flush_left = n_flush_left; m_wait_cnt = n_wait_cnt;
        m_stall = n_stall; m_flushes = n_flushes;
        m_waiting = n_waiting; m_fault = n_fault;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_rd = 0; mem_reg_write = 0;
        wb_rd = 0; wb_reg_write = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic load_use_rs2();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_flush", idex_flush, 1);
        chk("rst_stall", stall_cycles, 0);
        tick(); rst = 0;
        @(negedge clk);
        chk("run_pc_write", pc_write, 1);
        chk("run_ifid_flush", ifid_flush, 0);

        // forwarding
        tick();
        ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_reg_write = 1;
        wb_rd = 5; wb_reg_write = 1;
        @(negedge clk);
        chk("fwd_a_mem", fwd_a, 2'b10);
        chk("fwd_b_mem", fwd_b, 2'b10);
        tick(); mem_reg_write = 0;
        @(negedge clk);
        chk("fwd_a_wb", fwd_a, 2'b01);
        tick(); mem_reg_write = 1; ex_rs1 = 0; mem_rd = 0; wb_rd = 0;
        @(negedge clk);
        chk("fwd_a_x0", fwd_a, 2'b00);
        tick(); idle();

        // load-use
        tick(); load_use_rs2();
        @(negedge clk);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_idex_flush", idex_flush, 1);
        tick(); idle();
        @(negedge clk);
        chk("lu_release", pc_write, 1);
        chk("lu_stall", stall_cycles, 1);
        tick(); load_use_rs2(); id_use_rs2 = 0;
        @(negedge clk);
        chk("lu_unused_rs2", pc_write, 1);
        tick(); idle(); ex_mem_read = 1; id_use_rs1 = 1;
        @(negedge clk);
        chk("lu_x0", pc_write, 1);
        tick(); idle();

        // branch flush
        tick(); ex_branch_taken = 1;
        @(negedge clk);
        chk("br_pc_sel", pc_sel, 1);
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_idex_flush", idex_flush, 1);
        tick(); idle();
        @(negedge clk);
        chk("fl1_pc_sel", pc_sel, 0);
        chk("fl1_ifid_flush", ifid_flush, 1);
        chk("fl1_idex_flush", idex_flush, 0);
        tick();
        @(negedge clk);
        chk("fl2_ifid_flush", ifid_flush, 1);
        tick();
        @(negedge clk);
        chk("fl_done", ifid_flush, 0);
        chk("br_events", flush_events, 1);

        // branch beats load-use
        tick(); ex_branch_taken = 1; load_use_rs2();
        @(negedge clk);
        chk("brlu_pc_write", pc_write, 1);
        chk("brlu_pc_sel", pc_sel, 1);
        tick(); idle();
        tick();
        tick();
        @(negedge clk);
        chk("brlu_stall", stall_cycles, 1);
        chk("brlu_events", flush_events, 2);

        // memory wait with a branch pending
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_req = 1; dmem_ready = 0;
            ex_branch_taken = (i >= 1);
            @(negedge clk);
            chk("mw_hold", pipe_hold, 1);
            chk("mw_pc_write", pc_write, 0);
            chk("mw_pc_sel", pc_sel, 0);
        end
        tick(); dmem_ready = 1;
        @(negedge clk);
        chk("mw_rel_hold", pipe_hold, 0);
        chk("mw_rel_pc_write", pc_write, 1);
        chk("mw_rel_pc_sel", pc_sel, 1);
        tick(); idle();
        @(negedge clk);
        chk("mw_stall", stall_cycles, 5);
        chk("mw_events", flush_events, 3);
        tick();
        tick();

        // timeout
        for (int i = 1; i <= MT; i++) begin
            tick(); dmem_req = 1; dmem_ready = 0;
            @(negedge clk);
            chk("to_no_fault", fault, 0);
        end
        tick();
        @(negedge clk);
        chk("to_fault", fault, 1);
        for (int i = 0; i < 260; i++) begin
            tick();
            dmem_req = (i < 130);
        end
        @(negedge clk);
        chk("to_sticky", fault, 1);
        chk("to_pc_write", pc_write, 0);
        chk("stall_sat", stall_cycles, SAT);

        // reset clears fault and counters
        tick(); rst = 1; idle();
        @(negedge clk);
        chk("rst2_pc_write", pc_write, 0);
        chk("rst2_hold", pipe_hold, 0);
        tick(); rst = 0;
        @(negedge clk);
        chk("rst2_fault", fault, 0);
        chk("rst2_stall", stall_cycles, 0);
        chk("rst2_events", flush_events, 0);
        chk("rst2_run", pc_write, 1);

        // reset in the middle of a flush
        tick(); ex_branch_taken = 1;
        tick(); ex_branch_taken = 0; rst = 1;
        @(negedge clk);
        chk("rstfl_pc_write", pc_write, 0);
        chk("rstfl_pc_sel", pc_sel, 0);
        chk("rstfl_idex_flush", idex_flush, 1);
        tick(); rst = 0;
        @(negedge clk);
        chk("rstfl_pc_write_after", pc_write, 1);
        chk("rstfl_ifid_flush_after", ifid_flush, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
